// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port 64-bit data memory with a valid/ready request channel and a
//   valid/ready response channel. One request may be outstanding at a time.
//   A request is accepted in IDLE; stores commit and load data is captured
//   on the accept edge. The response is presented LATENCY cycles later (the
//   accept cycle counts as the first) and held until the requester takes it.
//
//   Parameters
//     ADDR_WIDTH  byte-address width; memory holds 2^(ADDR_WIDTH-3) words
//     LATENCY     accept-to-response latency, 1..15
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset (memory is not cleared)
//     req_valid_i  request present
//     req_ready_o  responder idle and able to accept
//     req_we_i     1 = store, 0 = load
//     req_addr_i   byte address
//     req_wdata_i  store data, right-aligned
//     req_wid_i    RV64 funct3 access width / extension select
//     rsp_valid_o  response present
//     rsp_ready_i  requester takes the response
//     rsp_rdata_o  extended load data; 0 for stores and errors
//     rsp_err_o    request was rejected
//
//   Build option
//     DMEM_RESPONDER_ALIGN_CHECK_EN  when defined, misaligned accesses are
//     rejected with rsp_err_o; otherwise the address is truncated to the
//     natural alignment of the access size.

module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [63:0]           req_wdata_i,
    input  logic [2:0]            req_wid_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int DATA_W = 64;
    localparam int WORDS  = 2 ** (ADDR_WIDTH - 3);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        live;

    logic [DATA_W-1:0] mem [WORDS];

    // Sign/zero extension of a right-aligned raw load value per funct3.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0]        wid);
        logic signed [7:0]        b_s;
        logic signed [15:0]       h_s;
        logic signed [31:0]       w_s;
        logic signed [DATA_W-1:0] r_s;
        b_s = raw[7:0];
        h_s = raw[15:0];
        w_s = raw[31:0];
        r_s = '0;
        case (wid)
            3'b000:  r_s = b_s;
            3'b001:  r_s = h_s;
            3'b010:  r_s = w_s;
            3'b011:  r_s = raw;
            3'b100:  r_s = {56'd0, raw[7:0]};
            3'b101:  r_s = {48'd0, raw[15:0]};
            3'b110:  r_s = {32'd0, raw[31:0]};
            default: r_s = '0;
        endcase
        return r_s;
    endfunction

    // ---- stage p0: request decode (combinational, on the accept cycle) ----
    logic                  accept_p0;
    logic [2:0]            off_mask_p0;
    logic [2:0]            off_p0;
    logic                  misaligned_p0;
    logic                  illegal_p0;
    logic                  err_p0;
    logic [DATA_W-1:0]     mask_base_p0;
    logic [DATA_W-1:0]     wmask_p0;
    logic [DATA_W-1:0]     wdata_sh_p0;
    logic [ADDR_WIDTH-4:0] idx_p0;
    logic [DATA_W-1:0]     rd_word_p0;
    logic [DATA_W-1:0]     rd_sh_p0;

    assign req_ready_o = live && (state == S_IDLE);
    assign accept_p0   = req_valid_i && req_ready_o;
    assign idx_p0      = req_addr_i[ADDR_WIDTH-1:3];

    always_comb begin
        off_mask_p0   = 3'b000;
        misaligned_p0 = 1'b0;
        mask_base_p0  = '1;
        case (req_wid_i[1:0])
            2'd0: begin
                off_mask_p0   = 3'b111;
                misaligned_p0 = 1'b0;
                mask_base_p0  = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                off_mask_p0   = 3'b110;
                misaligned_p0 = req_addr_i[0];
                mask_base_p0  = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                off_mask_p0   = 3'b100;
                misaligned_p0 = |req_addr_i[1:0];
                mask_base_p0  = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                off_mask_p0   = 3'b000;
                misaligned_p0 = |req_addr_i[2:0];
                mask_base_p0  = '1;
            end
        endcase
    end

    // Low offset bits below the access size are dropped, so an unchecked
    // misaligned access lands on its naturally aligned container.
    assign off_p0 = req_addr_i[2:0] & off_mask_p0;

    // funct3 111 is never legal; the unsigned encodings have no store form.
    assign illegal_p0 = (req_wid_i == 3'b111) || (req_we_i && req_wid_i[2]);
    assign err_p0     = illegal_p0 || (ALIGN_CHECK && misaligned_p0);

    assign wmask_p0    = mask_base_p0 << {off_p0, 3'b000};
    assign wdata_sh_p0 = req_wdata_i  << {off_p0, 3'b000};
    assign rd_word_p0  = mem[idx_p0];
    assign rd_sh_p0    = rd_word_p0 >> {off_p0, 3'b000};

    // Storage has no reset: contents survive reset by design.
    always_ff @(posedge clk_i) begin
        if (accept_p0 && req_we_i && !err_p0) begin
            mem[idx_p0] <= (rd_word_p0 & ~wmask_p0) | (wdata_sh_p0 & wmask_p0);
        end
    end

    // ---- stage p1: response register, held until the response handshake ----
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept_p0) begin
            err_p1   <= err_p0;
            rdata_p1 <= (err_p0 || req_we_i) ? '0 : extend(rd_sh_p0, req_wid_i);
        end
    end

    assign rsp_valid_o = (state == S_RESP);
    assign rsp_rdata_o = rdata_p1;
    assign rsp_err_o   = err_p1;

    // Control state. `live` keeps req_ready_o low until the first edge after
    // reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            live  <= 1'b1;
        end
    end

    // The counter holds the cycles still to wait; the WAIT step that brings
    // it to zero is also the step into RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept_p0) begin
                    cnt_nxt = CNT_INIT;
                    if (LATENCY <= 1) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule
